// File: rtl/bcd_pkg.sv
// Shared widths, limits and state encoding for the BCD setpoint entry path.
// Used by bcd_dabble_step and bcd2bin_entry.
package bcd_pkg;

   localparam int BCD_W   = 4;
   localparam int N_DIG   = 3;
   localparam int BIN_W   = 10;
   localparam int OUT_W   = 8;
   localparam int N_STEPS = 10;

   localparam int ENT_W   = N_DIG * BCD_W;
   localparam int WORK_W  = ENT_W + BIN_W;
   localparam int CNT_W   = 4;

   localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
   localparam logic [OUT_W-1:0] OUT_MAX   = 8'd255;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } b2b_state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One reverse double-dabble iteration on the {bcd, bin} working word.
// Ports: work_i (current word), work_o (shifted right, digits >=8 minus 3).
module bcd_dabble_step
   import bcd_pkg::*;
(
   input  logic [WORK_W-1:0] work_i,
   output logic [WORK_W-1:0] work_o
);

   logic [WORK_W-1:0] sh;

   always_comb begin
      sh     = {1'b0, work_i[WORK_W-1:1]};
      work_o = sh;
      // A digit of 8+ after the shift means it borrowed 10 from the
      // digit above as 16/2 = 8; take away 3 to make it 10/2 = 5.
      for (int d = 0; d < N_DIG; d++) begin
         if (sh[BIN_W + d*BCD_W +: BCD_W] >= 4'd8) begin
            work_o[BIN_W + d*BCD_W +: BCD_W] =
               sh[BIN_W + d*BCD_W +: BCD_W] - 4'd3;
         end
      end
   end

endmodule

// File: rtl/bcd2bin_entry.sv
// 3-digit BCD setpoint entry plus iterative BCD-to-binary conversion.
// Ports: clk_i, rst_ni, digit_valid_i, digit_i, enter_i, clr_i in;
//        digits_o, bin_o, ovf_o, err_o, busy_o, done_o out.
// Option: BCD2BIN_SATURATE_EN clamps results above 255 to 255.
module bcd2bin_entry
   import bcd_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             digit_valid_i,
   input  logic [BCD_W-1:0] digit_i,
   input  logic             enter_i,
   input  logic             clr_i,
   output logic [ENT_W-1:0] digits_o,
   output logic [OUT_W-1:0] bin_o,
   output logic             ovf_o,
   output logic             err_o,
   output logic             busy_o,
   output logic             done_o
);

   b2b_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [ENT_W-1:0]  ent_q,   ent_d;
   logic [WORK_W-1:0] work_q,  work_d;
   logic [OUT_W-1:0]  bin_q,   bin_d;
   logic              ovf_q,   ovf_d;
   logic              err_q,   err_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;

   logic [WORK_W-1:0] step_w;
   logic [BIN_W-1:0]  res;
   logic              res_big;

   bcd_dabble_step u_step (
      .work_i (work_q),
      .work_o (step_w)
   );

   assign res     = work_q[BIN_W-1:0];
   assign res_big = res > {2'b00, OUT_MAX};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ent_d   = ent_q;
      work_d  = work_q;
      bin_d   = bin_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (clr_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         ent_d   = '0;
         err_d   = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enter_i) begin
                  work_d  = {ent_q, {BIN_W{1'b0}}};
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = CONV;
               end else if (digit_valid_i) begin
                  if (digit_i <= BCD_MAX) begin
                     ent_d = {ent_q[ENT_W-BCD_W-1:0], digit_i};
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            CONV: begin
               work_d = step_w;
               if (cnt_q == LAST_STEP) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               ovf_d   = res_big;
`ifdef BCD2BIN_SATURATE_EN
               bin_d   = res_big ? OUT_MAX : res[OUT_W-1:0];
`else
               bin_d   = res[OUT_W-1:0];
`endif
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ent_q   <= '0;
         work_q  <= '0;
         bin_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ent_q   <= ent_d;
         work_q  <= work_d;
         bin_q   <= bin_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign digits_o = ent_q;
   assign bin_o    = bin_q;
   assign ovf_o    = ovf_q;
   assign err_o    = err_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_bcd2bin_entry.sv
// Directed bench for bcd2bin_entry with a result scoreboard.
// Expected conversions come from a decimal model of the entry register.
module tb_bcd2bin_entry;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        digit_valid_i;
   logic [3:0]  digit_i;
   logic        enter_i;
   logic        clr_i;
   logic [11:0] digits_o;
   logic [7:0]  bin_o;
   logic        ovf_o;
   logic        err_o;
   logic        busy_o;
   logic        done_o;

   bcd2bin_entry dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .digit_valid_i (digit_valid_i),
      .digit_i       (digit_i),
      .enter_i       (enter_i),
      .clr_i         (clr_i),
      .digits_o      (digits_o),
      .bin_o         (bin_o),
      .ovf_o         (ovf_o),
      .err_o         (err_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [8:0]  exp_q[$];
   logic [11:0] model_ent = '0;
   logic [7:0]  last_bin  = '0;
   logic        last_ovf  = 1'b0;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic put_digit(input logic [3:0] d);
      digit_valid_i = 1'b1;
      digit_i       = d;
      tick();
      digit_valid_i = 1'b0;
      if (d <= 4'd9) model_ent = {model_ent[7:0], d};
   endtask

   task automatic do_clr();
      clr_i = 1'b1;
      tick();
      clr_i     = 1'b0;
      model_ent = '0;
   endtask

   function automatic int model_val();
      return int'(model_ent[11:8]) * 100 +
             int'(model_ent[7:4])  * 10  +
             int'(model_ent[3:0]);
   endfunction

   // noise: offer digits with enter and mid-conversion; both must be dropped.
   task automatic convert(input string tag, input bit noise);
      int         v;
      int         n;
      logic       eo;
      logic [7:0] eb;
      logic [8:0] e;
      v  = model_val();
      eo = v > 255;
`ifdef BCD2BIN_SATURATE_EN
      eb = eo ? 8'd255 : 8'(v);
`else
      eb = 8'(v);
`endif
      exp_q.push_back({eo, eb});
      enter_i = 1'b1;
      if (noise) begin
         digit_valid_i = 1'b1;
         digit_i       = 4'd5;
      end
      tick();
      enter_i       = 1'b0;
      digit_valid_i = 1'b0;
      check({tag, "_busy"}, 32'(busy_o), 32'd1);
      n = 0;
      while (!done_o && n < 20) begin
         if (noise && n == 3) begin
            digit_valid_i = 1'b1;
            digit_i       = 4'd7;
            enter_i       = 1'b1;
         end
         tick();
         digit_valid_i = 1'b0;
         enter_i       = 1'b0;
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'd11);
      e = exp_q.pop_front();
      check({tag, "_bin"}, 32'(bin_o), 32'(e[7:0]));
      check({tag, "_ovf"}, 32'(ovf_o), 32'(e[8]));
      check({tag, "_bsy0"}, 32'(busy_o), 32'd0);
      check({tag, "_dig"}, 32'(digits_o), 32'(model_ent));
      last_bin = e[7:0];
      last_ovf = e[8];
      tick();
      check({tag, "_pulse"}, 32'(done_o), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_dig"},  32'(digits_o), 32'd0);
      check({tag, "_bin"},  32'(bin_o),    32'd0);
      check({tag, "_ovf"},  32'(ovf_o),    32'd0);
      check({tag, "_err"},  32'(err_o),    32'd0);
      check({tag, "_busy"}, 32'(busy_o),   32'd0);
      check({tag, "_done"}, 32'(done_o),   32'd0);
   endtask

   initial begin
      bit seen;
      rst_ni        = 1'b0;
      digit_valid_i = 1'b0;
      digit_i       = '0;
      enter_i       = 1'b0;
      clr_i         = 1'b0;
      #12;
      check_reset_vals("rst");
      rst_ni = 1'b1;
      tick();

      put_digit(4'd1);
      put_digit(4'd2);
      put_digit(4'd7);
      check("d127", 32'(digits_o), 32'h127);
      convert("c127", 1'b0);
      convert("re127", 1'b1);

      do_clr();
      put_digit(4'd1);
      put_digit(4'd2);
      put_digit(4'd3);
      put_digit(4'd4);
      check("d234", 32'(digits_o), 32'h234);
      convert("c234", 1'b0);

      do_clr();
      put_digit(4'd9);
      put_digit(4'd9);
      put_digit(4'd9);
      convert("c999", 1'b0);

      do_clr();
      put_digit(4'd5);
      put_digit(4'hA);
      check("bad_dig", 32'(digits_o), 32'h005);
      check("bad_err", 32'(err_o), 32'd1);
      convert("c5", 1'b0);
      check("err_sticky", 32'(err_o), 32'd1);
      do_clr();
      check("clr_err", 32'(err_o), 32'd0);
      convert("c0", 1'b0);

      put_digit(4'd4);
      put_digit(4'd2);
      convert("c42", 1'b0);

      // abort a conversion with clr at E5
      do_clr();
      put_digit(4'd2);
      put_digit(4'd0);
      put_digit(4'd0);
      enter_i = 1'b1;
      tick();
      enter_i = 1'b0;
      repeat (4) tick();
      clr_i = 1'b1;
      tick();
      clr_i     = 1'b0;
      model_ent = '0;
      seen      = 1'b0;
      for (int i = 0; i < 15; i++) begin
         seen |= done_o;
         tick();
      end
      check("abort_done", 32'(seen), 32'd0);
      check("abort_bin", 32'(bin_o), 32'(last_bin));
      check("abort_ovf", 32'(ovf_o), 32'(last_ovf));
      check("abort_dig", 32'(digits_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      convert("post_abort", 1'b0);

      // async reset in the middle of a conversion
      put_digit(4'd1);
      put_digit(4'd5);
      put_digit(4'd0);
      enter_i = 1'b1;
      tick();
      enter_i = 1'b0;
      repeat (4) tick();
      #2;
      rst_ni = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      model_ent = '0;
      tick();
      rst_ni = 1'b1;
      seen   = 1'b0;
      for (int i = 0; i < 12; i++) begin
         seen |= done_o;
         tick();
      end
      check("rst_no_done", 32'(seen), 32'd0);
      put_digit(4'd8);
      put_digit(4'd0);
      put_digit(4'd9);
      convert("c809", 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd2bin_entry.md
# bcd2bin_entry

Accepts a setpoint typed as decimal digits and converts it to the 8-bit binary temperature format used by the display path. Digits arrive one at a time as BCD and are shifted into a 3-digit entry register. That register is exported for echo on the 7-segment display. On `enter_i` an iterative reverse double-dabble (shift-right, subtract-3) runs for 10 cycles and produces `bin_o` with a single-cycle `done_o`. It is the inverse of the binary-to-BCD temperature path.

## Interface
- No parameters; all widths come from the shared package.
- `clk_i`  in  1  system clock, all state on rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `digit_valid_i`  in  1  `digit_i` is offered this cycle
- `digit_i`  in  4  BCD digit; 0..9 legal
- `enter_i`  in  1  start conversion of entry register
- `clr_i`  in  1  synchronous clear/abort
- `digits_o`  out  12  entry register {cen, dec, uni}, for display echo
- `bin_o`  out  8  converted value, registered
- `ovf_o`  out  1  last converted value exceeded 255
- `err_o`  out  1  sticky: an illegal digit (>9) was offered
- `busy_o`  out  1  conversion in progress
- `done_o`  out  1  one-cycle pulse, result written

## Operation
- States: IDLE, CONV, DONE.
- Reset values (async, on `rst_ni`=0): state IDLE; `digits_o`=0; `bin_o`=0; `ovf_o`=0; `err_o`=0; `busy_o`=0; `done_o`=0; iteration counter 0.
- Priority within a cycle, highest first: `clr_i`, then `enter_i`, then `digit_valid_i`.
- `clr_i`, any state:
  - Entry register and `err_o` go to 0; state goes to IDLE.
  - An in-flight conversion is discarded. `bin_o` and `ovf_o` keep their old values, and `done_o` does not fire.
- IDLE with `digit_valid_i`, `digit_i`≤9: shift left, {cen,dec,uni} ← {dec,uni,digit}. A 4th digit drops the oldest.
- IDLE with `digit_valid_i`, `digit_i`>9: entry register unchanged; `err_o` ← 1.
- IDLE with `enter_i`:
  - Snapshot the entry register into a 12-bit BCD working register.
  - Clear the 10-bit binary working register and the counter.
  - Go to CONV. A simultaneous digit is dropped.
- CONV, one step per cycle, 10 steps:
  - Shift {bcd, bin} right by 1 as a 22-bit unit.
  - Then, in each BCD digit of the shifted word, if the digit is ≥8, subtract 3.
  - After step 10, go to DONE.
- CONV ignores `digit_valid_i` and `enter_i`. The entry register is not modified, so `digits_o` is stable during conversion.
- DONE:
  - Write `bin_o` and `ovf_o` from the 10-bit result (see Configuration).
  - `ovf_o` = (result > 255).
  - `done_o`=1 for one cycle, then go to IDLE.
- The entry register is retained after conversion. A repeat `enter_i` reconverts the same value.
- Arithmetic: the result is exact for 0..999; 10 bits covers the maximum of 999.

## Timing
- `enter_i` is sampled at edge E0: `busy_o`=1 from E0; steps occur at E1..E10.
- At E11: `bin_o`/`ovf_o` update, `done_o`=1, `busy_o`=0.
- At E12: `done_o`=0, IDLE. Earliest next accepted `enter_i` is at E12.
- Latency from `enter_i` to `done_o` is 11 clocks; all outputs are registered.
- A digit accepted at edge E appears on `digits_o` after E.
- Reset deassertion mid-conversion: the block starts in IDLE with all outputs at reset values; no partial result.

## Configuration
- `BCD2BIN_SATURATE_EN` defined: when the result exceeds 255, `bin_o`=255 and `ovf_o`=1.
- Undefined: `bin_o` = result[7:0] (mod 256), and `ovf_o` is still set on results above 255.

## Structure
- Package `bcd_pkg` holds:
  - `BCD_W`=4, `N_DIG`=3, `BIN_W`=10, `OUT_W`=8, `N_STEPS`=10.
  - State enum `b2b_state_t` {IDLE, CONV, DONE}.
  - Constants `BCD_MAX`=9 and `OUT_MAX`=255.
- One combinational sub-module, `bcd_dabble_step`, implements a single reverse double-dabble iteration (22-bit right shift plus per-digit ≥8 → −3 correction).

## Test plan
- Digits 1,2,7 then `enter_i` → after 11 clocks `done_o` pulses once, `bin_o`=127, `ovf_o`=0, `digits_o`=0x127.
- Digits 1,2,3,4 → `digits_o`=0x234; enter → `bin_o`=234.
- Digits 9,9,9 then enter → `ovf_o`=1; `bin_o`=255 with `BCD2BIN_SATURATE_EN`, 231 without.
- Digit 0xA after 0x05 → `digits_o` stays 0x005, `err_o`=1 until `clr_i`; enter with no digits after clear → `bin_o`=0.
- Digits 2,0,0, enter, `clr_i` at E5 → no `done_o`, `bin_o` keeps its prior value, `digits_o`=0, IDLE. In a separate run, `rst_ni` low at E5 → all outputs at reset values.
